rabbit_spawner: RTL and testbench

- Produces the one-hot "rabbit" LED position that the score block compares against the snake position.
- Owns the rabbit's life cycle: spawn at a pseudo-random position not under the snake; hold until eaten; clear; wait a respawn delay; respawn.
- Consumes the score block's eat/clear pulse.
- Drives the 8-bit rabbit vector, which is the score block's second comparison input.

---
 rtl/rabbit_spawner.sv | 153 +++++++++++++++
 tb/tb_rabbit_spawner.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rabbit_spawner.sv
// rabbit_spawner
//   Owns the rabbit's life cycle for the snake game. It spawns a one-hot rabbit
//   position chosen from an 8-bit LFSR that never lands under the snake. The
//   rabbit is held until the score block reports an eat on the snake's
//   position. The board then stays clear for RESPAWN_TICKS game steps before
//   the rabbit respawns.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   tick         one-cycle game-step strobe
//   eaten        eat/clear level from the score block; only its rising edge is used
//   snake_led    current snake position (one-hot, 0 = no snake)
//   rabbit_led   current rabbit position (one-hot or 0)
//   rabbit_valid high while a rabbit is shown
//   spawn_pulse  one-cycle strobe when a new rabbit position first appears
//   spawn_count  spawns since reset, modulo 16
module rabbit_spawner #(
  parameter int         RESPAWN_TICKS = 4,
  parameter logic [7:0] LFSR_SEED     = 8'hB5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       eaten,
  input  logic [7:0] snake_led,
  output logic [7:0] rabbit_led,
  output logic       rabbit_valid,
  output logic       spawn_pulse,
  output logic [3:0] spawn_count
);

  localparam int         WAIT_W    = (RESPAWN_TICKS < 1) ? 1 : $clog2(RESPAWN_TICKS + 1);
  localparam logic [7:0] SEED_EFF  = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RESPAWN_TICKS);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  typedef enum logic [1:0] {
    ST_PICK = 2'd0,
    ST_SHOW = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Galois right-shift step, taps x^8+x^6+x^5+x^4+1. A nonzero state never
  // maps to zero, so the register cannot lock up.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    lfsr_step = (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
  endfunction

  state_t            state, state_nxt;
  logic [7:0]        lfsr;
  logic              eaten_d;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [7:0]        led_nxt;
  logic              valid_nxt;
  logic              pulse_nxt;
  logic [3:0]        count_nxt;

  logic              eat_rise;
  logic              eat_hit;
  logic [7:0]        cand;
  logic [7:0]        cand_rot;
  logic              pick_ok;
  logic [7:0]        pick_led;

  assign eat_rise = eaten & ~eaten_d;
  assign eat_hit  = eat_rise & (|(snake_led & rabbit_led));

  // Candidate comes from the LFSR; if the snake covers it, try the next LED
  // over. Since the snake is one-hot, at most one of the two is blocked.
  always_comb begin
    cand     = 8'b1 << lfsr[2:0];
    cand_rot = {cand[6:0], cand[7]};
    pick_ok  = 1'b0;
    pick_led = 8'h00;
    if ((cand & snake_led) == 8'h00) begin
      pick_ok  = 1'b1;
      pick_led = cand;
    end else if ((cand_rot & snake_led) == 8'h00) begin
      pick_ok  = 1'b1;
      pick_led = cand_rot;
    end
  end

  always_comb begin
    state_nxt = state;
    led_nxt   = rabbit_led;
    valid_nxt = rabbit_valid;
    pulse_nxt = 1'b0;
    count_nxt = spawn_count;
    wait_nxt  = wait_cnt;
    case (state)
      ST_PICK: begin
        if (pick_ok) begin
          led_nxt   = pick_led;
          valid_nxt = 1'b1;
          pulse_nxt = 1'b1;
          count_nxt = spawn_count + 4'd1;
          state_nxt = ST_SHOW;
        end
      end
      ST_SHOW: begin
        // An eat on a tick wins; the tick is not counted toward the wait.
        if (eat_hit) begin
          led_nxt   = 8'h00;
          valid_nxt = 1'b0;
          wait_nxt  = WAIT_LOAD;
          state_nxt = (RESPAWN_TICKS == 0) ? ST_PICK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tick) begin
          if (wait_cnt > WAIT_ONE) begin
            wait_nxt = wait_cnt - WAIT_ONE;
          end else begin
            wait_nxt  = '0;
            state_nxt = ST_PICK;
          end
        end
      end
      default: state_nxt = ST_PICK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_PICK;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr         <= SEED_EFF;
      eaten_d      <= 1'b0;
      wait_cnt     <= '0;
      rabbit_led   <= 8'h00;
      rabbit_valid <= 1'b0;
      spawn_pulse  <= 1'b0;
      spawn_count  <= 4'd0;
    end else begin
      lfsr         <= lfsr_step(lfsr);
      eaten_d      <= eaten;
      wait_cnt     <= wait_nxt;
      rabbit_led   <= led_nxt;
      rabbit_valid <= valid_nxt;
      spawn_pulse  <= pulse_nxt;
      spawn_count  <= count_nxt;
    end
  end

endmodule

// File: tb/tb_rabbit_spawner.sv
module tb_rabbit_spawner;

  localparam int PH_PICK = 0;
  localparam int PH_SHOW = 1;
  localparam int PH_WAIT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       eaten = 1'b0;
  logic [7:0] snake_led = 8'h00;

  // instance 0: RESPAWN_TICKS=3, instance 1: RESPAWN_TICKS=0
  logic [7:0] led_a, led_b;
  logic       valid_a, valid_b, pulse_a, pulse_b;
  logic [3:0] cnt_a, cnt_b;

  logic [7:0] d_led[2];
  logic       d_valid[2];
  logic       d_pulse[2];
  logic [3:0] d_cnt[2];

  assign d_led[0] = led_a;   assign d_led[1] = led_b;
  assign d_valid[0] = valid_a; assign d_valid[1] = valid_b;
  assign d_pulse[0] = pulse_a; assign d_pulse[1] = pulse_b;
  assign d_cnt[0] = cnt_a;   assign d_cnt[1] = cnt_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rabbit_spawner #(.RESPAWN_TICKS(3), .LFSR_SEED(8'hB5)) dut_a (
    .clk(clk), .rst(rst), .tick(tick), .eaten(eaten), .snake_led(snake_led),
    .rabbit_led(led_a), .rabbit_valid(valid_a), .spawn_pulse(pulse_a), .spawn_count(cnt_a)
  );

  rabbit_spawner #(.RESPAWN_TICKS(0), .LFSR_SEED(8'hB5)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .eaten(eaten), .snake_led(snake_led),
    .rabbit_led(led_b), .rabbit_valid(valid_b), .spawn_pulse(pulse_b), .spawn_count(cnt_b)
  );

  // Behavioural reference: phase + countdown of remaining ticks, per instance.
  int         m_rt[2] = '{3, 0};
  int         m_phase[2];
  int         m_left[2];
  int         m_cnt[2];
  logic [7:0] m_led[2];
  logic       m_pulse[2];
  logic [7:0] m_lfsr[2];
  logic       m_eprev[2];
  logic [7:0] mc, mc2;
  logic       m_rise;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_phase[i] = PH_PICK; m_left[i] = 0; m_cnt[i] = 0; m_led[i] = 8'h00;
        m_pulse[i] = 1'b0; m_lfsr[i] = 8'hB5; m_eprev[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_rise = eaten && !m_eprev[i];
        m_pulse[i] = 1'b0;
        if (m_phase[i] == PH_PICK) begin
          mc  = 8'd1 << (m_lfsr[i] % 8);
          mc2 = {mc[6:0], mc[7]};
          if ((mc & snake_led) != 0) mc = mc2;
          if ((mc & snake_led) == 0) begin
            m_led[i] = mc; m_pulse[i] = 1'b1; m_cnt[i] = (m_cnt[i] + 1) % 16;
            m_phase[i] = PH_SHOW;
          end
        end else if (m_phase[i] == PH_SHOW) begin
          if (m_rise && ((snake_led & m_led[i]) != 0)) begin
            m_led[i] = 8'h00;
            m_left[i] = m_rt[i];
            m_phase[i] = (m_rt[i] == 0) ? PH_PICK : PH_WAIT;
          end
        end else begin
          if (tick) begin
            m_left[i] = m_left[i] - 1;
            if (m_left[i] <= 0) begin m_left[i] = 0; m_phase[i] = PH_PICK; end
          end
        end
        m_lfsr[i] = m_lfsr[i][0] ? ((m_lfsr[i] >> 1) ^ 8'hB8) : (m_lfsr[i] >> 1);
        m_eprev[i] = eaten;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for two edges and releases it just after an edge.
  task automatic do_reset(input logic [7:0] snake_v);
    rst = 1'b1; tick = 1'b0; eaten = 1'b0; snake_led = snake_v;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b0; eaten = 1'b0; snake_led = 8'h00;
    cyc(); cyc();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (d_led[i] !== 8'h00 || d_valid[i] !== 1'b0 || d_pulse[i] !== 1'b0 || d_cnt[i] !== 4'd0) begin
        failures++;
        $display("FAIL reset_state[%0d]: led=%h valid=%b pulse=%b cnt=%0d want 00/0/0/0",
                 i, d_led[i], d_valid[i], d_pulse[i], d_cnt[i]);
      end
    end
    rst = 1'b0;
    cyc();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (d_led[i] !== 8'h20 || d_valid[i] !== 1'b1 || d_pulse[i] !== 1'b1 || d_cnt[i] !== 4'd1) begin
        failures++;
        $display("FAIL first_spawn[%0d]: led=%h valid=%b pulse=%b cnt=%0d want 20/1/1/1",
                 i, d_led[i], d_valid[i], d_pulse[i], d_cnt[i]);
      end
    end
    cyc();
    checks++;
    if (d_pulse[0] !== 1'b0 || d_led[0] !== 8'h20) begin
      failures++;
      $display("FAIL pulse_one_cycle: pulse=%b led=%h want 0/20", d_pulse[0], d_led[0]);
    end
  endtask

  task automatic test_collision();
    do_reset(8'h20);
    cyc();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (d_led[i] !== 8'h40 || d_pulse[i] !== 1'b1) begin
        failures++;
        $display("FAIL collision_spawn[%0d]: led=%h pulse=%b want 40/1", i, d_led[i], d_pulse[i]);
      end
    end
  endtask

  task automatic test_eat_delay();
    logic [7:0] pos;
    logic [3:0] prev_cnt;
    do_reset(8'h00);
    cyc();
    pos = d_led[0];
    prev_cnt = d_cnt[0];
    snake_led = pos; eaten = 1'b1;
    cyc();
    eaten = 1'b0;
    checks++;
    if (d_led[0] !== 8'h00 || d_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL eat_clear: led=%h valid=%b want 00/0", d_led[0], d_valid[0]);
    end
    for (int t = 0; t < 3; t++) begin
      cyc(); cyc();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      checks++;
      if (d_led[0] !== 8'h00) begin
        failures++;
        $display("FAIL wait_hold_t%0d: led=%h want 00", t, d_led[0]);
      end
    end
    cyc();
    checks++;
    if (d_led[0] == 8'h00 || (d_led[0] & pos) != 8'h00 || !$onehot(d_led[0]) ||
        d_cnt[0] !== prev_cnt + 4'd1 || d_pulse[0] !== 1'b1 || d_led[0] !== m_led[0]) begin
      failures++;
      $display("FAIL respawn: led=%h cnt=%0d pulse=%b want led=%h (not %h) cnt=%0d pulse=1",
               d_led[0], d_cnt[0], d_pulse[0], m_led[0], pos, prev_cnt + 4'd1);
    end
  endtask

  task automatic test_spurious_held();
    int clears;
    logic prev_valid;
    do_reset(8'h00);
    cyc();
    snake_led = 8'h01; eaten = 1'b1;
    cyc();
    eaten = 1'b0;
    cyc();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (d_led[i] !== 8'h20 || d_valid[i] !== 1'b1) begin
        failures++;
        $display("FAIL spurious_eat[%0d]: led=%h valid=%b want 20/1", i, d_led[i], d_valid[i]);
      end
    end
    snake_led = d_led[0]; eaten = 1'b1;
    clears = 0;
    prev_valid = d_valid[0];
    for (int k = 0; k < 20; k++) begin
      tick = (k == 3 || k == 6 || k == 9);
      if (k == 12) snake_led = d_led[0];
      cyc();
      if (prev_valid && !d_valid[0]) clears++;
      prev_valid = d_valid[0];
      checks++;
      if (d_led[0] !== m_led[0] || d_led[1] !== m_led[1]) begin
        failures++;
        $display("FAIL held_track_k%0d: a=%h b=%h want a=%h b=%h", k, d_led[0], d_led[1], m_led[0], m_led[1]);
      end
    end
    tick = 1'b0;
    checks++;
    if (clears != 1 || d_valid[0] !== 1'b1 || d_led[0] !== snake_led) begin
      failures++;
      $display("FAIL held_eat_once: clears=%0d valid=%b led=%h want 1/1/%h", clears, d_valid[0], d_led[0], snake_led);
    end
    eaten = 1'b0;
  endtask

  task automatic test_simul_tick();
    do_reset(8'h00);
    cyc();
    snake_led = d_led[1]; eaten = 1'b1; tick = 1'b1;
    cyc();
    eaten = 1'b0; tick = 1'b0;
    checks++;
    if (d_led[1] !== 8'h00 || d_valid[1] !== 1'b0 || d_led[0] !== 8'h00) begin
      failures++;
      $display("FAIL simul_clear: b=%h bvalid=%b a=%h want 00/0/00", d_led[1], d_valid[1], d_led[0]);
    end
    cyc();
    checks++;
    if (d_led[1] == 8'h00 || d_pulse[1] !== 1'b1 || d_cnt[1] !== 4'd2 || d_led[1] !== m_led[1]) begin
      failures++;
      $display("FAIL simul_respawn: led=%h pulse=%b cnt=%0d want %h/1/2", d_led[1], d_pulse[1], d_cnt[1], m_led[1]);
    end
    // instance 0 must still need all three ticks
    for (int t = 0; t < 2; t++) begin
      tick = 1'b1; cyc(); tick = 1'b0; cyc();
    end
    checks++;
    if (d_led[0] !== 8'h00) begin
      failures++;
      $display("FAIL simul_tick_ignored: led=%h want 00", d_led[0]);
    end
    tick = 1'b1; cyc(); tick = 1'b0; cyc();
    checks++;
    if (d_led[0] == 8'h00 || d_led[0] !== m_led[0] || d_cnt[0] !== 4'd2) begin
      failures++;
      $display("FAIL simul_a_respawn: led=%h cnt=%0d want %h/2", d_led[0], d_cnt[0], m_led[0]);
    end
  endtask

  task automatic test_async_reset();
    do_reset(8'h00);
    cyc();
    snake_led = d_led[0]; eaten = 1'b1;
    cyc();
    eaten = 1'b0; snake_led = 8'h00; tick = 1'b1;
    cyc();
    tick = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (d_led[i] !== 8'h00 || d_valid[i] !== 1'b0 || d_pulse[i] !== 1'b0 || d_cnt[i] !== 4'd0) begin
        failures++;
        $display("FAIL async_reset[%0d]: led=%h valid=%b pulse=%b cnt=%0d want 00/0/0/0",
                 i, d_led[i], d_valid[i], d_pulse[i], d_cnt[i]);
      end
    end
    cyc();
    rst = 1'b0;
    cyc();
    checks++;
    if (d_led[0] !== 8'h20 || d_cnt[0] !== 4'd1 || d_pulse[0] !== 1'b1) begin
      failures++;
      $display("FAIL after_async_reset: led=%h cnt=%0d pulse=%b want 20/1/1", d_led[0], d_cnt[0], d_pulse[0]);
    end
  endtask

  task automatic test_random();
    int r;
    do_reset(8'h00);
    for (int k = 0; k < 600; k++) begin
      tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) eaten = ~eaten;
      r = $urandom_range(0, 5);
      if (r == 0)      snake_led = 8'h00;
      else if (r <= 2) snake_led = d_led[$urandom_range(0, 1)];
      else             snake_led = 8'd1 << $urandom_range(0, 7);
      cyc();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (d_led[i] !== m_led[i] || d_valid[i] !== (m_led[i] != 8'h00) ||
            d_pulse[i] !== m_pulse[i] || d_cnt[i] !== 4'(m_cnt[i])) begin
          failures++;
          $display("FAIL random_k%0d[%0d]: led=%h valid=%b pulse=%b cnt=%0d want %h/%b/%b/%0d",
                   k, i, d_led[i], d_valid[i], d_pulse[i], d_cnt[i],
                   m_led[i], (m_led[i] != 8'h00), m_pulse[i], m_cnt[i]);
        end
      end
    end
    tick = 1'b0; eaten = 1'b0;
  endtask

  initial begin
    test_reset();
    test_collision();
    test_eat_delay();
    test_spurious_held();
    test_simul_tick();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
